// File: rtl/phase_seq.sv
// Instruction-cycle phase sequencer: run/halt/step/stall control, decoded timing strobes, completed-cycle counter.
// Optional stall watchdog is compiled in when PHASE_SEQ_STALL_WDT_EN is defined.
module phase_seq #(
    parameter int PHASES       = 8,
    parameter int PHASE_W      = 3,
    parameter int FETCH_PHASES = 4,
    parameter int ALU_PHASE    = 6,
    parameter int CNT_W        = 16,
    parameter int STALL_LIMIT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               step,
    input  logic               stall,
    output logic [PHASE_W-1:0] phase,
    output logic               fetch,
    output logic               clk2,
    output logic               alu_en,
    output logic               cycle_start,
    output logic               running,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               stall_err,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam logic [PHASE_W-1:0] LAST_V  = PHASE_W'(PHASES - 1);
    localparam logic [PHASE_W-1:0] ALU_V   = PHASE_W'(ALU_PHASE);
    localparam logic [PHASE_W:0]   FETCH_V = (PHASE_W + 1)'(FETCH_PHASES);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic               halt_pend_q, halt_pend_d;
    logic               alu_en_q, alu_en_d;
    logic               cycle_start_q, cycle_start_d;
    logic               run_q, run_d, adv, stall_eff;

    assign run_q = (state_q == S_RUN) || (state_q == S_STEP);
    assign adv   = run_q && !stall_eff;

`ifdef PHASE_SEQ_STALL_WDT_EN
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_ign_q, stall_ign_d;
    logic            stall_err_q, stall_err_d;

    // Once tripped, stall is masked until the requester drops it for a cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_ign_d = stall_ign_q;
        stall_err_d = stall_err_q;
        if (!stall) begin
            stall_cnt_d = '0;
            stall_ign_d = 1'b0;
        end else if (run_q && !stall_ign_q) begin
            if (stall_cnt_q == SC_W'(STALL_LIMIT - 1)) begin
                stall_err_d = 1'b1;
                stall_ign_d = 1'b1;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_ign_q <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_ign_q <= stall_ign_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_eff = stall && !stall_ign_q;
    assign stall_err = stall_err_q;
`else
    logic stall_limit_unused;
    assign stall_limit_unused = (STALL_LIMIT != 0);
    assign stall_eff          = stall;
    assign stall_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            instr_cnt_q   <= '0;
            halt_pend_q   <= 1'b0;
            alu_en_q      <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            instr_cnt_q   <= instr_cnt_d;
            halt_pend_q   <= halt_pend_d;
            alu_en_q      <= alu_en_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        instr_cnt_d = instr_cnt_q;
        halt_pend_d = halt_pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN, S_STEP: begin
                if (state_q == S_RUN && halt) halt_pend_d = 1'b1;
                if (adv) begin
                    if (phase_q == LAST_V) begin
                        // A halt arriving in the last phase still counts for this wrap.
                        phase_d     = '0;
                        instr_cnt_d = instr_cnt_q + 1'b1;
                        halt_pend_d = 1'b0;
                        if (state_q == S_STEP || halt_pend_q || (state_q == S_RUN && halt))
                            state_d = S_HALTED;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (start)     state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes fire only when the phase is newly entered, never while held by stall.
        run_d         = (state_d == S_RUN) || (state_d == S_STEP);
        alu_en_d      = run_d && (adv || !run_q) && (phase_d == ALU_V);
        cycle_start_d = run_d && (adv || !run_q) && (phase_d == '0);
    end

    always_comb begin
        phase       = phase_q;
        running     = run_q;
        fetch       = run_q && ({1'b0, phase_q} < FETCH_V);
        clk2        = run_q && !phase_q[0];
        alu_en      = alu_en_q;
        cycle_start = cycle_start_q;
        instr_cnt   = instr_cnt_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: vector table on the default-size instance, hand sequences on CNT_W=4 and PHASES=2 instances.
module tb_phase_seq;

    localparam logic [4:0] I_0 = 5'b00000;
    localparam logic [4:0] I_R = 5'b10000;
    localparam logic [4:0] I_S = 5'b01000;
    localparam logic [4:0] I_H = 5'b00100;
    localparam logic [4:0] I_P = 5'b00010;
    localparam logic [4:0] I_L = 5'b00001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halt = 1'b0;
    logic step = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  m_phase;
    logic        m_fetch, m_clk2, m_alu, m_cs, m_run, m_err;
    logic [15:0] m_cnt;
    logic [1:0]  m_state;

    logic [2:0]  s_phase;
    logic        s_fetch, s_clk2, s_alu, s_cs, s_run, s_err;
    logic [3:0]  s_cnt;
    logic [1:0]  s_state;

    logic        t_phase;
    logic        t_fetch, t_clk2, t_alu, t_cs, t_run, t_err;
    logic [15:0] t_cnt;
    logic [1:0]  t_state;

    phase_seq #(.STALL_LIMIT(10)) u_main (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .step(step), .stall(stall),
        .phase(m_phase), .fetch(m_fetch), .clk2(m_clk2), .alu_en(m_alu), .cycle_start(m_cs),
        .running(m_run), .instr_cnt(m_cnt), .stall_err(m_err), .state_dbg(m_state)
    );

    phase_seq #(.CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .step(step), .stall(stall),
        .phase(s_phase), .fetch(s_fetch), .clk2(s_clk2), .alu_en(s_alu), .cycle_start(s_cs),
        .running(s_run), .instr_cnt(s_cnt), .stall_err(s_err), .state_dbg(s_state)
    );

    phase_seq #(.PHASES(2), .PHASE_W(1), .FETCH_PHASES(1), .ALU_PHASE(0)) u_tiny (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .step(step), .stall(stall),
        .phase(t_phase), .fetch(t_fetch), .clk2(t_clk2), .alu_en(t_alu), .cycle_start(t_cs),
        .running(t_run), .instr_cnt(t_cnt), .stall_err(t_err), .state_dbg(t_state)
    );

    typedef struct {
        string       name;
        logic [4:0]  in;
        logic [1:0]  e_state;
        logic [2:0]  e_phase;
        logic        e_fetch, e_clk2, e_alu, e_cs, e_run, e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    int errors = 0;
    int checks = 0;
    logic [26:0] exp_q[$];
    int          idx_q[$];
    logic [3:0]  sm_q[$];
    logic [2:0]  tn_q[$];

    task automatic add_v(input string nm, input logic [4:0] in, input int st, input int ph,
                         input logic alu, input logic cs, input int cnt, input logic err);
        vec_t v;
        v.name    = nm;
        v.in      = in;
        v.e_state = 2'(st);
        v.e_phase = 3'(ph);
        v.e_run   = (st == 1) || (st == 2);
        v.e_fetch = v.e_run && (ph < 4);
        v.e_clk2  = v.e_run && (ph % 2 == 0);
        v.e_alu   = alu;
        v.e_cs    = cs;
        v.e_err   = err;
        v.e_cnt   = 16'(cnt);
        vecs.push_back(v);
    endtask

    // Unstalled advance through n phases of an 8-phase cycle.
    task automatic adv(input string nm, input int n, input logic [4:0] in, input int st,
                       input logic err, inout int ph, inout int cnt);
        for (int i = 0; i < n; i++) begin
            ph = (ph + 1) % 8;
            if (ph == 0) cnt++;
            add_v(nm, in, st, ph, ph == 6, ph == 0, cnt, err);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        @(negedge clk);
        {reset, start, halt, step, stall} = in;
    endtask

    task automatic check_main();
        logic [26:0] e, a;
        int idx;
        e   = exp_q.pop_front();
        idx = idx_q.pop_front();
        a   = {m_state, m_phase, m_fetch, m_clk2, m_alu, m_cs, m_run, m_err, m_cnt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] {st,ph,fe,c2,alu,cs,run,err,cnt} got %h expected %h",
                     vecs[idx].name, idx, a, e);
        end
    endtask

    task automatic check_aux();
        logic [3:0] es;
        logic [2:0] et;
        es = sm_q.pop_front();
        et = tn_q.pop_front();
        checks++;
        if (s_cnt !== es) begin
            errors++;
            $display("FAIL small_cnt got %0d expected %0d", s_cnt, es);
        end
        checks++;
        if ({t_phase, t_alu, t_cs} !== et) begin
            errors++;
            $display("FAIL tiny {ph,alu,cs} got %b expected %b", {t_phase, t_alu, t_cs}, et);
        end
    endtask

    initial begin
        int ph;
        int cnt;

        add_v("reset", I_R, 0, 0, 0, 0, 0, 0);
        add_v("idle", I_0, 0, 0, 0, 0, 0, 0);
        add_v("start", I_S, 1, 0, 0, 1, 0, 0);
        ph = 0; cnt = 0;
        adv("run", 24, I_0, 1, 0, ph, cnt);
        adv("run", 2, I_0, 1, 0, ph, cnt);
        adv("halt", 1, I_H, 1, 0, ph, cnt);
        adv("drain", 4, I_0, 1, 0, ph, cnt);
        add_v("halted", I_0, 3, 0, 0, 0, 4, 0);
        add_v("halted_ign", I_H | I_L, 3, 0, 0, 0, 4, 0);
        add_v("step", I_P, 2, 0, 0, 1, 4, 0);
        ph = 0; cnt = 4;
        adv("step_run", 7, I_0, 2, 0, ph, cnt);
        add_v("step_done", I_0, 3, 0, 0, 0, 5, 0);
        add_v("start_step", I_S | I_P, 1, 0, 0, 1, 5, 0);
        ph = 0; cnt = 5;
        adv("cont", 8, I_0, 1, 0, ph, cnt);
        adv("to_alu", 6, I_0, 1, 0, ph, cnt);
        add_v("stall", I_L, 1, 6, 0, 0, 6, 0);
        add_v("stall", I_L, 1, 6, 0, 0, 6, 0);
        add_v("stall_halt", I_L | I_H, 1, 6, 0, 0, 6, 0);
        add_v("stall", I_L, 1, 6, 0, 0, 6, 0);
        add_v("stall", I_L, 1, 6, 0, 0, 6, 0);
        adv("stall_rel", 1, I_0, 1, 0, ph, cnt);
        add_v("halt_wrap", I_0, 3, 0, 0, 0, 7, 0);
        add_v("restart", I_S, 1, 0, 0, 1, 7, 0);
        ph = 0; cnt = 7;
        adv("to_p5", 5, I_0, 1, 0, ph, cnt);
        add_v("reset_mid", I_R, 0, 0, 0, 0, 0, 0);
        add_v("idle_ign", I_H | I_P | I_L, 0, 0, 0, 0, 0, 0);
`ifdef PHASE_SEQ_STALL_WDT_EN
        add_v("wdt_start", I_S, 1, 0, 0, 1, 0, 0);
        for (int s = 1; s <= 9; s++) add_v("wdt_stall", I_L, 1, 0, 0, 0, 0, 0);
        add_v("wdt_trip", I_L, 1, 0, 0, 0, 0, 1);
        ph = 0; cnt = 0;
        adv("wdt_ign", 10, I_L, 1, 1, ph, cnt);
        adv("wdt_rel", 1, I_0, 1, 1, ph, cnt);
        add_v("wdt_restall", I_L, 1, 3, 0, 0, 1, 1);
        add_v("wdt_restall", I_L, 1, 3, 0, 0, 1, 1);
        add_v("wdt_reset", I_R, 0, 0, 0, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            exp_q.push_back({vecs[i].e_state, vecs[i].e_phase, vecs[i].e_fetch, vecs[i].e_clk2,
                             vecs[i].e_alu, vecs[i].e_cs, vecs[i].e_run, vecs[i].e_err,
                             vecs[i].e_cnt});
            idx_q.push_back(i);
            @(posedge clk);
            #1;
            check_main();
        end

        // Counter wrap on a 4-bit instance and coincident strobes on a 2-phase instance.
        drive(I_R);
        sm_q.push_back(4'd0);
        tn_q.push_back(3'b000);
        @(posedge clk);
        #1;
        check_aux();
        drive(I_S);
        sm_q.push_back(4'd0);
        tn_q.push_back(3'b011);
        @(posedge clk);
        #1;
        check_aux();
        drive(I_0);
        for (int k = 1; k <= 136; k++) begin
            sm_q.push_back(4'((k / 8) % 16));
            tn_q.push_back({1'(k % 2), (k % 2 == 0), (k % 2 == 0)});
            @(posedge clk);
            #1;
            check_aux();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
Name: phase_seq

Overview:
- Single-clock, parametrised successor to the CPU's free-running clock/phase generator.
- Sequences each instruction cycle as PHASES clock cycles and decodes the timing controls from that count: fetch window, clk2-equivalent, one-shot ALU enable, cycle-start strobe.
- Adds start/halt/single-step/stall control and a completed-instruction counter.
- Feeds the state controller, address mux select and ALU enable in the top-level CPU.

Parameters:
- PHASES, 8, clock cycles per instruction cycle; legal range 2..2**PHASE_W.
- PHASE_W, 3, width of the phase counter.
- FETCH_PHASES, 4, phases 0..FETCH_PHASES-1 form the fetch window; must be < PHASES.
- ALU_PHASE, 6, phase at which alu_en pulses; must be < PHASES.
- CNT_W, 16, width of the completed-instruction counter.
- STALL_LIMIT, 255, stall watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: leave IDLE/HALTED and run continuously.
- halt  in  1  pulse: request a stop at the end of the current instruction cycle.
- step  in  1  pulse: in HALTED, run exactly one instruction cycle.
- stall  in  1  level: freeze the phase counter while high.
- phase  out  PHASE_W  current phase index.
- fetch  out  1  high while running and phase < FETCH_PHASES.
- clk2  out  1  high while running and phase[0]==0.
- alu_en  out  1  one-cycle pulse on entry into ALU_PHASE.
- cycle_start  out  1  one-cycle pulse on entry into phase 0 while running.
- running  out  1  high in RUN or STEP.
- instr_cnt  out  CNT_W  count of completed instruction cycles; wraps.
- stall_err  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- States: IDLE, RUN, STEP, HALTED.
- Reset: state=IDLE, phase=0, halt_pend=0, instr_cnt=0, stall_err=0. All outputs read 0.
- Reset has priority over every input and takes effect mid-cycle at any phase.
- IDLE:
  - start → RUN next cycle with phase=0; cycle_start=1 in that first RUN cycle.
  - step/halt/stall are ignored.
- RUN/STEP phase advance:
  - When stall=0: phase increments; PHASES-1 wraps to 0.
  - When stall=1: phase, state and alu_en source hold.
  - The wrap from PHASES-1 to 0 completes a cycle: instr_cnt+1 (modulo 2**CNT_W).
- halt_pend:
  - A halt pulse in RUN sets halt_pend.
  - It is sampled at the wrap: if set, go to HALTED, clear halt_pend, phase=0.
  - halt asserted in the PHASES-1 cycle itself counts for that wrap.
- STEP: at the wrap go to HALTED, phase=0, instr_cnt+1.
- HALTED:
  - start → RUN.
  - step → STEP.
  - start and step together: start wins.
  - halt is ignored.
- Output registration:
  - alu_en and cycle_start are registered, set on the cycle phase takes the matching value.
  - A stall while phase==ALU_PHASE does not re-pulse alu_en.
  - PHASES==2 with ALU_PHASE==0: alu_en and cycle_start coincide.
- Output decode:
  - fetch, clk2 and running are decoded only from registered state/phase.
  - There is no combinational path from any input to any output.
- Outside RUN/STEP: fetch, clk2, alu_en, cycle_start and running are 0.
- halt/step asserted while stalled are still captured.

Optional Feature:
- Macro: PHASE_SEQ_STALL_WDT_EN.
- Enabled:
  - A stall counter increments each cycle while stall=1 in RUN/STEP and clears when stall=0.
  - When it reaches STALL_LIMIT, stall_err sets (sticky until reset).
  - stall is then ignored until it deasserts for at least one cycle.
  - Phase resumes advancing on the cycle after stall_err sets.
- Disabled: no counter, stall_err=0, stall holds indefinitely.

Test Plan:
- reset, start at cycle 2 → phase 0,1..7,0; fetch high phases 0-3; alu_en one pulse at phase 6; cycle_start at each phase 0; instr_cnt=3 after 24 RUN cycles.
- halt pulse at phase 2 → finishes phase 7, enters HALTED with phase=0, running=0, instr_cnt incremented exactly once.
- HALTED, step pulse → exactly 8 running cycles with one alu_en, back to HALTED; start+step together → RUN continuously.
- stall high for 5 cycles at phase 6 → phase stays 6, single alu_en pulse, instruction takes 13 cycles; halt during stall is honoured at the wrap.
- reset asserted at phase 5 in RUN → next cycle IDLE, phase=0, instr_cnt=0, all outputs 0; CNT_W=4, 17 cycles → instr_cnt wraps to 1.
- With PHASE_SEQ_STALL_WDT_EN and STALL_LIMIT=10, stall held 20 cycles → stall_err=1 at the 10th stall cycle, phase advances the next cycle, flag stays set until reset.
